reaction_timer_ctrl: RTL
========================

# reaction_timer_ctrl

Sequencing controller for the reaction-timer datapath that follows the starting-lights FSM. It arms when a light sequence starts and detects a jump start if the key is pressed before lights-out. After lights-out it measures time to the key press in milliseconds and holds the result for the BCD/7-segment display. It also tracks the best valid time since reset or clear.

## Interface
Parameters:
- CNT_BITS, 14, width of millisecond counter and result registers
- MAX_MS, 9999, no-response limit in ms; must satisfy MAX_MS < 2^CNT_BITS − 1

Ports:
- clk  in  1  system clock (CLOCK_50 domain); single clock for the block
- rst_n  in  1  asynchronous, active-low reset
- tick_ms  in  1  one-clk-wide enable pulse every 1 ms (clktick output)
- arm  in  1  one-clk pulse: light sequence started
- lights_out  in  1  one-clk pulse: delay timeout, lights extinguished
- key_n  in  1  raw push-button, active-low, asynchronous to clk
- clear_best  in  1  one-clk pulse: reset best time
- state  out  3  current FSM state encoding
- rt_ms  out  CNT_BITS  last reaction time in ms
- rt_valid  out  1  level: rt_ms holds a valid measurement
- jump_start  out  1  level: press occurred before lights-out
- no_response  out  1  level: MAX_MS elapsed without press
- best_ms  out  CNT_BITS  best valid time; all-ones = none
- new_best  out  1  one-clk pulse when best_ms updated

## Operation
- Key input: 2-flop synchronizer, then falling-edge detector → press (one-clk pulse). Only edges count; a key held through arm is not a press.
- States: IDLE(0), ARMED(1), TIMING(2), DONE(3), JUMP(4), NORESP(5).
- IDLE: arm → ARMED.
- ARMED: press → JUMP; otherwise lights_out → TIMING with counter cleared to 0. If press and lights_out occur in the same cycle, press wins → JUMP.
- TIMING: counter increments on each tick_ms. press → DONE, rt_ms ← counter value, rt_valid ← 1. If press and tick_ms coincide, the pre-increment value is captured. Counter reaching MAX_MS with no press → NORESP, rt_ms ← MAX_MS, no_response ← 1.
- DONE/JUMP/NORESP: hold all outputs until arm → ARMED.
- Entering ARMED from any state, including abort mid-ARMED or mid-TIMING via arm, clears rt_valid, jump_start and no_response. rt_ms keeps its old value and is not meaningful while rt_valid=0.
- Best tracking: on entry to DONE, if the captured value < best_ms then best_ms ← captured value and new_best pulses. JUMP and NORESP never update best.
- clear_best sets best_ms to all-ones. If clear_best coincides with an update, clear wins and new_best = 0.
- Counter saturates at MAX_MS and never wraps.
- Outputs are mutually exclusive: at most one of rt_valid, jump_start, no_response is high.

## Timing
- Reset values: state=IDLE, rt_ms=0, rt_valid=0, jump_start=0, no_response=0, best_ms=all-ones, new_best=0, counter=0, synchronizer flops=1 (released key).
- Key latency: key_n falling edge → press pulse after 2–3 clk. State change and output registers update on the following edge, so rt_valid or jump_start is high ≤4 clk after the key edge.
- lights_out → TIMING on the next clk edge. The first increment occurs on the first tick_ms after entry.
- Resolution is 1 ms, truncated: the result is the number of tick_ms pulses seen in TIMING.
- new_best is high exactly one clk, coincident with the rt_valid rising edge.
- rst_n assertion mid-operation immediately forces the reset values. Deassertion is synchronised externally.

## Structure
- Shared package/include reaction_pkg: state encodings (ST_IDLE…ST_NORESP), state width 3, BEST_NONE all-ones constant.
- Sub-module key_sync_edge: 2-flop synchronizer plus falling-edge detector producing the press pulse. It is reused for other KEY inputs.
- Top integration: tick_ms comes from clktick (used as an enable, not a clock), arm comes from start_delay, lights_out comes from the delay timeout, and rt_ms feeds bin2bcd_16.

## Test plan
- Normal: arm, lights_out, 237 tick_ms, then key_n low → state=DONE, rt_ms=237, rt_valid=1, best_ms=237, new_best pulses once.
- Jump start: arm, key_n low before lights_out → state=JUMP, jump_start=1; a later lights_out is ignored and best_ms is unchanged.
- Same-cycle press and lights_out → JUMP. Same-cycle press and tick_ms at count 150 → rt_ms=150.
- No response: arm, lights_out, 9999 ticks with no press → NORESP, rt_ms=9999, no_response=1, best unchanged.
- Best logic: results 300 then 410 then 180 → best_ms 300, 300, 180; new_best pulses on the 1st and 3rd only. clear_best coinciding with a better result → best_ms=all-ones, no new_best.
- Abort/reset: arm during TIMING at count 50 → ARMED with flags cleared. rst_n low mid-TIMING → all reset values immediately; key held low through arm produces no press.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer controller: state encodings
// and the "no best time yet" marker.
package reaction_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_JUMP   = 3'd4,
    ST_NORESP = 3'd5
  } state_t;

  // All-ones marks "no valid best time"; users truncate to their own width.
  localparam logic [31:0] BEST_NONE = '1;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an active-low push-button followed by a
// falling-edge detector. press is a one-clk pulse on each new key press;
// a key that is already held low never produces a further pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Synchronize the raw key and keep one extra stage for edge detection;
  // all flops reset to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync2_d <= 1'b1;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign press = sync2_d & ~sync2;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencing controller. Arms on a light-sequence start,
// flags jump starts, measures lights-out-to-press time in ms, and tracks
// the best valid time since reset or clear_best.
//
// Handshake: arm, lights_out, clear_best and tick_ms are single-cycle
// strobes sampled on every rising clk edge; there is no back-pressure, so
// every strobe is consumed in the cycle it is seen.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CNT_BITS = 14,
  parameter int MAX_MS   = 9999
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_ms,
  input  logic                arm,
  input  logic                lights_out,
  input  logic                key_n,
  input  logic                clear_best,
  output logic [STATE_W-1:0]  state,
  output logic [CNT_BITS-1:0] rt_ms,
  output logic                rt_valid,
  output logic                jump_start,
  output logic                no_response,
  output logic [CNT_BITS-1:0] best_ms,
  output logic                new_best
);

  localparam logic [CNT_BITS-1:0] MAX_CNT  = CNT_BITS'(MAX_MS);
  localparam logic [CNT_BITS-1:0] BEST_ALL = CNT_BITS'(BEST_NONE);

  logic                press;
  state_t              st_q, st_n;
  logic [CNT_BITS-1:0] cnt_q, cnt_n;
  logic [CNT_BITS-1:0] rt_q, rt_n;
  logic [CNT_BITS-1:0] best_q, best_n;
  logic                valid_q, valid_n;
  logic                jump_q, jump_n;
  logic                noresp_q, noresp_n;
  logic                nb_q, nb_n;

  key_sync_edge u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      rt_q     <= '0;
      best_q   <= BEST_ALL;
      valid_q  <= 1'b0;
      jump_q   <= 1'b0;
      noresp_q <= 1'b0;
      nb_q     <= 1'b0;
    end else begin
      st_q     <= st_n;
      cnt_q    <= cnt_n;
      rt_q     <= rt_n;
      best_q   <= best_n;
      valid_q  <= valid_n;
      jump_q   <= jump_n;
      noresp_q <= noresp_n;
      nb_q     <= nb_n;
    end
  end

  // Next-state, counter, result and best-time logic. arm restarts from any
  // state; clear_best overrides any best update in the same cycle.
  always_comb begin
    st_n     = st_q;
    cnt_n    = cnt_q;
    rt_n     = rt_q;
    best_n   = best_q;
    valid_n  = valid_q;
    jump_n   = jump_q;
    noresp_n = noresp_q;
    nb_n     = 1'b0;

    if (arm) begin
      st_n     = ST_ARMED;
      cnt_n    = '0;
      valid_n  = 1'b0;
      jump_n   = 1'b0;
      noresp_n = 1'b0;
    end else begin
      case (st_q)
        ST_ARMED: begin
          if (press) begin
            st_n   = ST_JUMP;
            jump_n = 1'b1;
          end else if (lights_out) begin
            st_n  = ST_TIMING;
            cnt_n = '0;
          end
        end
        ST_TIMING: begin
          if (press) begin
            // Capture the pre-increment count even if a tick coincides.
            st_n    = ST_DONE;
            rt_n    = cnt_q;
            valid_n = 1'b1;
            if (cnt_q < best_q) begin
              best_n = cnt_q;
              nb_n   = 1'b1;
            end
          end else if (cnt_q == MAX_CNT) begin
            st_n     = ST_NORESP;
            rt_n     = MAX_CNT;
            noresp_n = 1'b1;
          end else if (tick_ms) begin
            // Increment only below MAX_CNT, so the counter saturates.
            cnt_n = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (clear_best) begin
      best_n = BEST_ALL;
      nb_n   = 1'b0;
    end
  end

  assign state       = st_q;
  assign rt_ms       = rt_q;
  assign rt_valid    = valid_q;
  assign jump_start  = jump_q;
  assign no_response = noresp_q;
  assign best_ms     = best_q;
  assign new_best    = nb_q;

endmodule
